// File: rtl/spi_slave_responder_pkg.sv
// Shared definitions for the SPI-mode SD command responder: FSM states,
// command indices, R1 status bits and fill/default constants.
package spi_slave_responder_pkg;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_DECODE,
        ST_FILL,
        ST_SEND
    } state_t;

    localparam logic [5:0] CMD_GO_IDLE         = 6'd0;
    localparam logic [5:0] CMD_SEND_IF_COND    = 6'd8;
    localparam logic [5:0] CMD_SET_BLOCKLEN    = 6'd16;
    localparam logic [5:0] CMD_SD_SEND_OP_COND = 6'd41;
    localparam logic [5:0] CMD_APP_CMD         = 6'd55;

    localparam logic [7:0] R1_IDLE    = 8'h01;
    localparam logic [7:0] R1_ILLEGAL = 8'h04;
    localparam logic [7:0] R1_CRC     = 8'h08;
    localparam logic [7:0] R1_PARAM   = 8'h40;

    localparam logic [7:0]  FILL_BYTE            = 8'hFF;
    localparam logic [31:0] DEFAULT_BLOCK_LENGTH = 32'd512;
    localparam logic [31:0] MAX_BLOCK_LENGTH     = 32'd512;

    function automatic logic [7:0] r1_status(input logic idle, input logic [7:0] flags);
        return flags | {7'b0, idle};
    endfunction

endpackage

// File: rtl/spi_resp_tx_buffer.sv
// Response byte buffer: emits NCR_BYTES fill bytes then the loaded 1..5 byte
// response over a valid/ready handshake; outputs are registered.
module spi_resp_tx_buffer
    import spi_slave_responder_pkg::*;
#(
    parameter int unsigned NCR_BYTES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [2:0]  load_len,
    input  logic [39:0] load_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    output logic        fill_last,
    output logic        send_last
);

    localparam logic [3:0] NCR = 4'(NCR_BYTES);

    logic [39:0] data_q;
    logic [2:0]  len_q;
    logic [3:0]  idx_q;
    logic [3:0]  last_idx;
    logic        accept;

    // Index runs over fill bytes first, then response bytes MSB-first.
    function automatic logic [7:0] byte_at(input logic [3:0] idx, input logic [39:0] data);
        logic [3:0] off;
        if (idx < NCR) begin
            return FILL_BYTE;
        end
        off = idx - NCR;
        case (off)
            4'd0:    return data[39:32];
            4'd1:    return data[31:24];
            4'd2:    return data[23:16];
            4'd3:    return data[15:8];
            4'd4:    return data[7:0];
            default: return FILL_BYTE;
        endcase
    endfunction

    assign accept    = tx_valid && tx_ready;
    assign last_idx  = NCR + {1'b0, len_q} - 4'd1;
    assign fill_last = accept && (NCR != 4'd0) && (idx_q == NCR - 4'd1);
    assign send_last = accept && (idx_q == last_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q   <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            tx_valid <= 1'b0;
            tx_byte  <= FILL_BYTE;
        end else if (load) begin
            data_q   <= load_data;
            len_q    <= load_len;
            idx_q    <= '0;
            tx_valid <= 1'b1;
            tx_byte  <= byte_at(4'd0, load_data);
        end else if (accept) begin
            if (idx_q == last_idx) begin
                idx_q    <= '0;
                tx_valid <= 1'b0;
                tx_byte  <= FILL_BYTE;
            end else begin
                idx_q   <= idx_q + 4'd1;
                tx_byte <= byte_at(idx_q + 4'd1, data_q);
            end
        end
    end

endmodule

// File: rtl/spi_slave_responder.sv
// SD-card SPI-mode command responder (CMD0/8/16/55/ACMD41).
// Optional macro SPI_SLAVE_RESPONDER_CRC_ERR_EN reports failed frame checks.
module spi_slave_responder
    import spi_slave_responder_pkg::*;
#(
    parameter int unsigned NCR_BYTES         = 1,
    parameter int unsigned ACMD41_BUSY_COUNT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_CommandReadFinished,
    input  logic        io_ArgumentReadFinished,
    input  logic        io_ReadSuccess,
    input  logic [5:0]  io_Command,
    input  logic [31:0] io_CommandArgument,
    input  logic        io_TxReady,
    output logic        io_TxValid,
    output logic [7:0]  io_TxByte,
    output logic        io_IdleState,
    output logic        io_AppCmd,
    output logic [31:0] io_BlockLength,
    output logic        io_Busy
);

    localparam logic [3:0] BUSY_COUNT = 4'(ACMD41_BUSY_COUNT);

    state_t      state_q, state_d;
    logic        arg_fin_q;
    logic        start;
    logic        idle_q, app_q;
    logic [3:0]  cnt_q;
    logic [31:0] blen_q;
    logic        load, fill_last, send_last;
    logic        crc_fail;
    logic        unused_inputs;

    logic        d_idle, d_app;
    logic [3:0]  d_cnt;
    logic [31:0] d_blen;
    logic [7:0]  d_r1;
    logic [2:0]  d_len;
    logic [39:0] d_data;

    assign start         = io_ArgumentReadFinished && !arg_fin_q;
    assign unused_inputs = ^{io_CommandReadFinished, io_ReadSuccess};

`ifdef SPI_SLAVE_RESPONDER_CRC_ERR_EN
    logic crc_ok_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc_ok_q <= 1'b1;
        end else if (state_q == ST_WAIT && start) begin
            crc_ok_q <= io_ReadSuccess;
        end
    end

    assign crc_fail = !crc_ok_q;
`else
    assign crc_fail = 1'b0;
`endif

    always_comb begin
        d_idle = idle_q;
        d_app  = 1'b0;
        d_cnt  = cnt_q;
        d_blen = blen_q;
        d_len  = 3'd1;
        d_r1   = r1_status(idle_q, 8'h00);
        if (crc_fail) begin
            d_app = app_q;
            d_r1  = r1_status(idle_q, R1_CRC);
        end else begin
            case (io_Command)
                CMD_GO_IDLE: begin
                    d_idle = 1'b1;
                    d_cnt  = '0;
                    d_r1   = R1_IDLE;
                end
                CMD_SEND_IF_COND: d_len = 3'd5;
                CMD_APP_CMD:      d_app = 1'b1;
                CMD_SET_BLOCKLEN: begin
                    if (io_CommandArgument != 32'd0 && io_CommandArgument <= MAX_BLOCK_LENGTH) begin
                        d_blen = io_CommandArgument;
                    end else begin
                        d_r1 = r1_status(idle_q, R1_PARAM);
                    end
                end
                CMD_SD_SEND_OP_COND: begin
                    if (app_q) begin
                        d_cnt = (cnt_q >= BUSY_COUNT) ? cnt_q : cnt_q + 4'd1;
                        if (d_cnt == BUSY_COUNT) begin
                            d_idle = 1'b0;
                        end
                        d_r1 = r1_status(d_idle, 8'h00);
                    end else begin
                        d_r1 = r1_status(idle_q, R1_ILLEGAL);
                    end
                end
                default: d_r1 = r1_status(idle_q, R1_ILLEGAL);
            endcase
        end
        if (d_len == 3'd5) begin
            d_data = {d_r1, 8'h00, 8'h00, {4'h0, io_CommandArgument[11:8]}, io_CommandArgument[7:0]};
        end else begin
            d_data = {d_r1, 32'h0};
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (start) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                load    = 1'b1;
                state_d = (NCR_BYTES > 0) ? ST_FILL : ST_SEND;
            end
            ST_FILL: begin
                if (fill_last) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (send_last) state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_WAIT;
            arg_fin_q <= 1'b0;
            idle_q    <= 1'b1;
            app_q     <= 1'b0;
            cnt_q     <= '0;
            blen_q    <= DEFAULT_BLOCK_LENGTH;
        end else begin
            state_q   <= state_d;
            arg_fin_q <= io_ArgumentReadFinished;
            if (state_q == ST_DECODE) begin
                idle_q <= d_idle;
                app_q  <= d_app;
                cnt_q  <= d_cnt;
                blen_q <= d_blen;
            end
        end
    end

    spi_resp_tx_buffer #(
        .NCR_BYTES(NCR_BYTES)
    ) u_tx_buffer (
        .clk       (clock),
        .rst       (reset),
        .load      (load),
        .load_len  (d_len),
        .load_data (d_data),
        .tx_ready  (io_TxReady),
        .tx_valid  (io_TxValid),
        .tx_byte   (io_TxByte),
        .fill_last (fill_last),
        .send_last (send_last)
    );

    assign io_IdleState   = idle_q;
    assign io_AppCmd      = app_q;
    assign io_BlockLength = blen_q;
    assign io_Busy        = (state_q != ST_WAIT);

endmodule

// File: doc/spi_slave_responder.md
SPI_SLAVE_RESPONDER -- requirements
Module: spi_slave_responder

Interface
REQ-001 Parameter NCR_BYTES, default 1, number of 0xFF fill bytes sent before each response (0..7).
REQ-002 Parameter ACMD41_BUSY_COUNT, default 2, number of accepted ACMD41 needed to leave idle (1..15).
REQ-003 clock  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high; forces the reset state immediately.
REQ-005 io_CommandReadFinished  in  1  command byte captured by the upstream receiver.
REQ-006 io_ArgumentReadFinished  in  1  argument and CRC captured; a 0->1 edge starts a response.
REQ-007 io_ReadSuccess  in  1  upstream CRC/frame check passed; valid with io_ArgumentReadFinished.
REQ-008 io_Command  in  6  command index.
REQ-009 io_CommandArgument  in  32  command argument, MSB first as received.
REQ-010 io_TxReady  in  1  downstream shift-out stage accepts io_TxByte this cycle.
REQ-011 io_TxValid  out  1  io_TxByte holds a byte to transmit.
REQ-012 io_TxByte  out  8  byte to transmit.
REQ-013 io_IdleState  out  1  card in idle (R1 bit 0).
REQ-014 io_AppCmd  out  1  next command is treated as ACMD.
REQ-015 io_BlockLength  out  32  block length set by CMD16.
REQ-016 io_Busy  out  1  high in any state other than WAIT.

Function
REQ-017 The FSM SHALL have states WAIT, DECODE, FILL, SEND; WAIT->DECODE on a registered rising edge of io_ArgumentReadFinished; DECODE->FILL (NCR_BYTES>0) or ->SEND; FILL->SEND after NCR_BYTES accepted 0xFF bytes; SEND->WAIT after the last response byte is accepted.
REQ-018 In DECODE the block SHALL latch io_Command/io_CommandArgument and build a 1- or 5-byte response buffer in one cycle; first io_TxValid SHALL be asserted the cycle after DECODE.
REQ-019 Handshake: a byte transfers when io_TxValid && io_TxReady; while io_TxValid && !io_TxReady, io_TxByte SHALL stay stable; io_TxValid SHALL be 0 in WAIT and DECODE.
REQ-020 CMD0: io_IdleState=1, ACMD41 counter=0, io_AppCmd=0, R1=0x01.
REQ-021 CMD8: R7 = {R1, 0x00, 0x00, {4'h0, arg[11:8]}, arg[7:0]}, sent in that order.
REQ-022 CMD55: io_AppCmd=1, R1={7'b0, idle}.
REQ-023 CMD41 with io_AppCmd=1: counter increments (saturating at ACMD41_BUSY_COUNT); on reaching it io_IdleState=0; R1 reports the updated idle bit.
REQ-024 CMD16: if 1<=arg<=512, io_BlockLength=arg and R1={7'b0,idle}; otherwise io_BlockLength unchanged and R1=0x40|idle.
REQ-025 Any other index, or CMD41 with io_AppCmd=0: R1=0x04|idle, no other state change.
REQ-026 io_AppCmd SHALL clear in DECODE of every command except CMD55.
REQ-027 A start edge arriving while io_Busy=1 SHALL be dropped with no state change; an edge coinciding with the SEND->WAIT transition SHALL also be dropped.
REQ-028 io_CommandReadFinished SHALL NOT start a response; it only qualifies io_Command for future use and is otherwise ignored.

Reset
REQ-029 On reset: state=WAIT, io_TxValid=0, io_TxByte=0xFF, io_IdleState=1, io_AppCmd=0, io_BlockLength=512, counter=0, io_Busy=0, edge detector=0.
REQ-030 Reset mid-response SHALL abort the transfer; no residual bytes SHALL be emitted after release.

Configuration
REQ-031 Macro SPI_SLAVE_RESPONDER_CRC_ERR_EN: when defined, io_ReadSuccess=0 at start SHALL skip all command effects and send R1=0x08|idle; when undefined, io_ReadSuccess SHALL be ignored.

Structure
REQ-032 A shared package SHALL hold the state enum, command indices (0,8,16,41,55), R1 bit masks (IDLE 0x01, ILLEGAL 0x04, CRC 0x08, PARAM 0x40), fill byte 0xFF and default block length 512.
REQ-033 One sub-module, spi_resp_tx_buffer, SHALL hold the 5-byte buffer, byte index and length, and drive the handshake.

Verification
REQ-034 Reset, CMD0 arg 0, io_TxReady=1 -> bytes 0xFF, 0x01; io_IdleState=1.
REQ-035 CMD8 arg 0x000001AA -> 0xFF, 0x01, 0x00, 0x00, 0x01, 0xAA.
REQ-036 CMD55, ACMD41, CMD55, ACMD41 -> R1 0x01, 0x01, 0x01, 0x00; io_IdleState falls after the second ACMD41.
REQ-037 CMD16 arg 1024 -> 0x41 (idle) and io_BlockLength stays 512; CMD16 arg 512 -> R1 without PARAM bit.
REQ-038 CMD41 without CMD55, then CMD55 twice with io_TxReady toggling every other cycle -> 0x05, then R1 bytes held stable under backpressure and exact byte count.
REQ-039 Reset asserted during the 3rd R7 byte -> io_TxValid=0 at once; next CMD0 -> 0xFF, 0x01; with the macro defined, io_ReadSuccess=0 -> 0x09.
